keypad_scanner: RTL and testbench

- Input-side counterpart of the MMIO store path: scans a 4x4 matrix keypad, debounces it, and queues key-press events for CPU loads at MMIO 0x0014 (keypad word).
- The MMIO controller instantiates it in the fpga_clk domain.
- The controller maps the key_data output into the keypad register.
- The controller strobes pop on each CPU read of 0x0014.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/kp_event_fifo.sv | 89 ++++++++
 rtl/keypad_scanner.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key legend and MMIO word layout for the keypad scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } kp_state_t;

    // Indexed by snapshot code c*4+r, packed MSB-first (entry 15 listed first).
    // Column 3 = D C B A, column 2 = # 9 6 3, column 1 = 0 8 5 2, column 0 = * 7 4 1.
    localparam logic [15:0][3:0] KP_VALUE_MAP = {
        4'd13, 4'd12, 4'd11, 4'd10,
        4'd15, 4'd9,  4'd6,  4'd3,
        4'd0,  4'd8,  4'd5,  4'd2,
        4'd14, 4'd7,  4'd4,  4'd1
    };

    // key_data field positions
    localparam int KD_NONEMPTY_BIT = 31;
    localparam int KD_OVF_BIT      = 30;
    localparam int KD_COUNT_LSB    = 8;
    localparam int KD_VALUE_LSB    = 0;

    // Code of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] kp_first_code(input logic [15:0] snap);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (snap[i]) code = 4'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// Key-event queue: ring of DEPTH entries with KEYPAD_FIFO_EN, else one holding register.
// Latency: enqueue/pop visible on head_val/count the cycle after the strobe.
// Backpressure: none; full+enq drops (ring) or overwrites (register) and sets sticky overflow.
module kp_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       fpga_clk,
    input  logic       rst,
    input  logic       enq,
    input  logic [3:0] enq_val,
    input  logic       pop,
    output logic [3:0] head_val,
    output logic [2:0] count,
    output logic       overflow
);

    // The count field in key_data is three bits wide.
    if (DEPTH < 2 || DEPTH > 7) begin : g_depth_range
        $error("kp_event_fifo: DEPTH must be in 2..7");
    end

    logic pop_ok;
    logic full;

    assign pop_ok = pop && (count != 3'd0);

`ifdef KEYPAD_FIFO_EN
    logic [3:0] mem [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic       push_ok;

    function automatic logic [2:0] next_ptr(input logic [2:0] p);
        return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // A simultaneous pop frees a slot, so a full queue still accepts the push.
    assign full    = (count == 3'(DEPTH));
    assign push_ok = enq && (!full || pop_ok);

    // Storage needs no reset: count gates every read.
    always_ff @(posedge fpga_clk) begin
        if (push_ok) mem[wr_ptr] <= enq_val;
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + {2'b00, push_ok} - {2'b00, pop_ok};
            if (pop_ok)           overflow <= 1'b0;
            else if (enq && full) overflow <= 1'b1;
        end
    end

    assign head_val = (count != 3'd0) ? mem[rd_ptr] : 4'd0;
`else
    logic [3:0] hold_val;

    assign full = (count != 3'd0);

    // Newest event always wins the single slot; losing an unread one is flagged.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            hold_val <= 4'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (enq) begin
                hold_val <= enq_val;
                count    <= 3'd1;
            end else if (pop_ok) begin
                count    <= 3'd0;
            end
            if (pop_ok)           overflow <= 1'b0;
            else if (enq && full) overflow <= 1'b1;
        end
    end

    assign head_val = full ? hold_val : 4'd0;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan, ghost-rejecting debounce and event queue for the MMIO keypad word (KEYPAD_FIFO_EN selects ring queue).
// Latency: enqueue one cycle after the deciding snapshot completes, key_data one cycle after that.
// Backpressure: none; pop is a strobe, a full queue drops or overwrites and sets overflow.
module keypad_scanner #(
    parameter int SCAN_PERIOD_CYC = 100000,
    parameter int DEBOUNCE_SCANS  = 20,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        fpga_clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        pop,
    output logic [31:0] key_data,
    output logic        key_pressed
);
    import keypad_pkg::*;

    localparam int CYC_W = $clog2(SCAN_PERIOD_CYC);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CYC_W-1:0] DWELL_LAST = CYC_W'(SCAN_PERIOD_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [CYC_W-1:0] dwell_cnt;
    logic [1:0]       col_idx;
    logic [11:0]      snap_acc;
    logic [15:0]      snap;
    logic             snap_vld;
    logic             snap_none;
    logic             snap_single;
    logic [3:0]       snap_code;
    kp_state_t        state;
    kp_state_t        state_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_cnt_nxt;
    logic [3:0]       cand;
    logic [3:0]       cand_nxt;
    logic             enq;
    logic [3:0]       q_head;
    logic [2:0]       q_count;
    logic             q_ovf;
    logic [31:0]      kd_nxt;

    assign col_out = ~(4'b0001 << col_idx);

    // Two-flop synchronizer; idle rows read as pulled-up.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Column dwell; rows sampled on the last dwell cycle and shifted in so column 0 lands at bits 3:0.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            snap_acc  <= 12'd0;
            snap      <= 16'd0;
            snap_vld  <= 1'b0;
        end else begin
            snap_vld <= 1'b0;
            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                snap_acc  <= {~row_sync, snap_acc[11:4]};
                if (col_idx == 2'd3) begin
                    snap     <= {~row_sync, snap_acc};
                    snap_vld <= 1'b1;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    assign snap_none   = (snap == 16'd0);
    assign snap_single = !snap_none && ((snap & (snap - 16'd1)) == 16'd0);
    assign snap_code   = kp_first_code(snap);

    // Debounce decision, evaluated once per completed scan; multi-key snapshots never qualify.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        cand_nxt    = cand;
        enq         = 1'b0;
        if (snap_vld) begin
            case (state)
                IDLE: begin
                    if (snap_single) begin
                        state_nxt   = DEB_PRESS;
                        cand_nxt    = snap_code;
                        deb_cnt_nxt = DEB_W'(1);
                    end
                end
                DEB_PRESS: begin
                    if (snap_single && snap_code == cand) begin
                        if (deb_cnt == DEB_LAST) begin
                            enq         = 1'b1;
                            state_nxt   = HELD;
                            deb_cnt_nxt = '0;
                        end else begin
                            deb_cnt_nxt = deb_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt   = IDLE;
                        deb_cnt_nxt = '0;
                    end
                end
                HELD: begin
                    if (snap_none) begin
                        state_nxt   = DEB_RELEASE;
                        deb_cnt_nxt = DEB_W'(1);
                    end
                end
                default: begin
                    if (snap_none) begin
                        if (deb_cnt == DEB_LAST) begin
                            state_nxt   = IDLE;
                            deb_cnt_nxt = '0;
                        end else begin
                            deb_cnt_nxt = deb_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt   = HELD;
                        deb_cnt_nxt = '0;
                    end
                end
            endcase
        end
    end

    // Debounce state and the held-key indicator.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            cand        <= 4'd0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_cnt_nxt;
            cand        <= cand_nxt;
            key_pressed <= (state_nxt == HELD) || (state_nxt == DEB_RELEASE);
        end
    end

    kp_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .fpga_clk(fpga_clk),
        .rst     (rst),
        .enq     (enq),
        .enq_val (KP_VALUE_MAP[cand]),
        .pop     (pop),
        .head_val(q_head),
        .count   (q_count),
        .overflow(q_ovf)
    );

    // Assemble the MMIO word; unused bits stay zero.
    always_comb begin
        kd_nxt                            = 32'd0;
        kd_nxt[KD_NONEMPTY_BIT]           = (q_count != 3'd0);
        kd_nxt[KD_OVF_BIT]                = q_ovf;
        kd_nxt[KD_COUNT_LSB +: 3]         = q_count;
        kd_nxt[KD_VALUE_LSB +: 4]         = q_head;
    end

    // Registered MMIO word.
    always_ff @(posedge fpga_clk or posedge rst) begin
        if (rst) key_data <= 32'd0;
        else     key_data <= kd_nxt;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad emulation driven off col_out, scan-level reference model.
// Latency: outputs compared mid-scan, well clear of snapshot and pop update edges.
// Backpressure: n/a.
module tb_keypad_scanner;

    localparam int PERIOD = 4;
    localparam int DEB    = 3;
    localparam int DEPTH  = 4;

    logic        fpga_clk;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        pop;
    logic [31:0] key_data;
    logic        key_pressed;

    logic [15:0] keys_drv;
    logic [3:0]  exp_col;
    int checks = 0;
    int errors = 0;
    event do_check;

    // Reference model state: event queue plus debounce progress expressed as run lengths.
    int q[$];
    bit m_ovf;
    bit m_held;
    int m_pcnt;
    int m_rcnt;
    int m_cand;
    bit pend_valid;
    logic [15:0] pend_keys;

    // Legend by [row][col].
    int legend [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    keypad_scanner #(
        .SCAN_PERIOD_CYC(PERIOD),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .fpga_clk   (fpga_clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .pop        (pop),
        .key_data   (key_data),
        .key_pressed(key_pressed)
    );

    initial begin
        fpga_clk = 1'b0;
        forever #5 fpga_clk = ~fpga_clk;
    end

    // Physical keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys_drv[c*4 + r]) row_in[r] = 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] kmask(input int r, input int c);
        return 16'(1) << (c*4 + r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        q.delete();
        m_ovf = 0; m_held = 0; m_pcnt = 0; m_rcnt = 0; m_cand = 0;
        pend_valid = 0;
    endfunction

    function automatic void m_pop();
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 0;
        end
    endfunction

    function automatic void m_push(input int v);
`ifdef KEYPAD_FIFO_EN
        if (q.size() < DEPTH) q.push_back(v);
        else m_ovf = 1;
`else
        if (q.size() == 0) q.push_back(v);
        else begin
            q[0] = v;
            m_ovf = 1;
        end
`endif
    endfunction

    // One full-matrix scan's worth of debounce rules.
    function automatic void m_snapshot(input logic [15:0] s);
        int pc;
        int code;
        pc = $countones(s);
        code = 0;
        for (int i = 15; i >= 0; i--) if (s[i]) code = i;
        if (!m_held) begin
            if (m_pcnt > 0) begin
                if (pc == 1 && code == m_cand) begin
                    m_pcnt++;
                    if (m_pcnt == DEB) begin
                        m_push(legend[code % 4][code / 4]);
                        m_held = 1;
                        m_pcnt = 0;
                    end
                end else begin
                    m_pcnt = 0;
                end
            end else if (pc == 1) begin
                m_cand = code;
                m_pcnt = 1;
            end
        end else begin
            if (m_rcnt > 0) begin
                if (pc == 0) begin
                    m_rcnt++;
                    if (m_rcnt == DEB) begin
                        m_held = 0;
                        m_rcnt = 0;
                    end
                end else begin
                    m_rcnt = 0;
                end
            end else if (pc == 0) begin
                m_rcnt = 1;
            end
        end
    endfunction

    function automatic logic [31:0] model_kd();
        logic [31:0] e;
        e = 32'd0;
        if (q.size() > 0) begin
            e[31]  = 1'b1;
            e[3:0] = 4'(q[0]);
        end
        e[30]   = m_ovf;
        e[10:8] = 3'(q.size());
        return e;
    endfunction

    // Single compare point against the model.
    always @(do_check) begin
        chk("key_data", key_data, model_kd());
        chk("key_pressed", 32'(key_pressed), 32'(m_held));
        chk("col_out", 32'(col_out), 32'(exp_col));
    end

    // Called at the negedge opening a scan; returns at scan offset 4 after the model check.
    task automatic begin_scan(input logic [15:0] k, input bit pop_now);
        keys_drv = k;
        if (pop_now) begin
            pop = 1'b1;
            m_pop();
        end
        if (pend_valid) m_snapshot(pend_keys);
        pend_keys  = k;
        pend_valid = 1;
        @(negedge fpga_clk);
        pop = 1'b0;
        repeat (3) @(negedge fpga_clk);
        exp_col = 4'b1101;
        ->do_check;
    endtask

    // From scan offset 4 to the negedge opening the next scan.
    task automatic finish_scan(input bit pop_mid);
        repeat (4) @(negedge fpga_clk);
        if (pop_mid) begin
            pop = 1'b1;
            m_pop();
        end
        @(negedge fpga_clk);
        pop = 1'b0;
        repeat (3) @(negedge fpga_clk);
        exp_col = 4'b0111;
        ->do_check;
        repeat (4) @(negedge fpga_clk);
    endtask

    task automatic run_scan(input logic [15:0] k, input int pmode);
        begin_scan(k, pmode == 1);
        finish_scan(pmode == 2);
    endtask

    task automatic scans(input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) run_scan(k, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rk;
        int sel;
        rst = 1'b1;
        pop = 1'b0;
        keys_drv = 16'd0;
        exp_col = 4'b1110;
        m_reset();
        repeat (3) @(negedge fpga_clk);
        chk("reset_col_out", 32'(col_out), 32'h0000_000E);
        chk("reset_key_data", key_data, 32'h0000_0000);
        chk("reset_key_pressed", 32'(key_pressed), 32'd0);
        rst = 1'b0;

        // '5' held: event after the third matching scan.
        scans(kmask(1, 1), 2);
        begin_scan(kmask(1, 1), 0);
        chk("five_before_event", key_data, 32'h0000_0000);
        finish_scan(0);
        begin_scan(kmask(1, 1), 0);
        chk("five_event", key_data, 32'h8000_0105);
        chk("five_model", model_kd(), 32'h8000_0105);
        chk("five_pressed", 32'(key_pressed), 32'd1);
        finish_scan(0);
        scans(kmask(1, 1), 2);
        run_scan(16'd0, 2);
        chk("five_popped", key_data, 32'h0000_0000);
        scans(16'd0, 1);
        begin_scan(16'd0, 0);
        chk("five_release_pending", 32'(key_pressed), 32'd1);
        finish_scan(0);
        begin_scan(16'd0, 0);
        chk("five_released", 32'(key_pressed), 32'd0);
        chk("five_no_repeat", key_data, 32'h0000_0000);
        finish_scan(0);

        // '9' bouncing, then held: exactly one event.
        for (int i = 0; i < 8; i++) run_scan((i % 2 == 0) ? kmask(2, 2) : 16'd0, 0);
        scans(kmask(2, 2), 4);
        begin_scan(16'd0, 0);
        chk("nine_single_event", key_data, 32'h8000_0109);
        finish_scan(0);
        run_scan(16'd0, 2);
        chk("nine_drained", key_data, 32'h0000_0000);
        run_scan(16'd0, 0);

        // '1' and '2' together: ghosting, never accepted.
        scans(kmask(0, 0) | kmask(0, 1), 10);
        begin_scan(16'd0, 0);
        chk("multi_no_event", key_data, 32'h0000_0000);
        chk("multi_not_pressed", 32'(key_pressed), 32'd0);
        finish_scan(0);

`ifdef KEYPAD_FIFO_EN
        // 1 2 3 A B without popping: B is dropped.
        scans(kmask(0, 0), 3); scans(16'd0, 3);
        scans(kmask(0, 1), 3); scans(16'd0, 3);
        scans(kmask(0, 2), 3); scans(16'd0, 3);
        scans(kmask(0, 3), 3); scans(16'd0, 3);
        scans(kmask(1, 3), 3); scans(16'd0, 3);
        begin_scan(16'd0, 0);
        chk("fifo_full_ovf", key_data, 32'hC000_0401);
        finish_scan(1);
        chk("fifo_pop1", key_data, 32'h8000_0302);
        run_scan(16'd0, 2);
        chk("fifo_pop2", key_data, 32'h8000_0203);
        run_scan(16'd0, 2);
        chk("fifo_pop3", key_data, 32'h8000_010A);
`else
        // 4 then 7 without popping: 7 overwrites, overflow set.
        scans(kmask(1, 0), 3); scans(16'd0, 3);
        scans(kmask(2, 0), 3); scans(16'd0, 3);
        begin_scan(16'd0, 0);
        chk("reg_overwrite", key_data, 32'hC000_0107);
        finish_scan(0);
`endif

        // Reset in the middle of debouncing '#'.
        scans(kmask(3, 2), 2);
        begin_scan(kmask(3, 2), 0);
        repeat (2) @(negedge fpga_clk);
        rst = 1'b1;
        #1;
        chk("rst_col_out", 32'(col_out), 32'h0000_000E);
        chk("rst_key_data", key_data, 32'h0000_0000);
        chk("rst_key_pressed", 32'(key_pressed), 32'd0);
        repeat (3) @(negedge fpga_clk);
        rst = 1'b0;
        m_reset();
        scans(kmask(3, 2), 2);
        begin_scan(kmask(3, 2), 0);
        chk("rst_no_early_event", key_data, 32'h0000_0000);
        finish_scan(0);
        begin_scan(kmask(3, 2), 0);
        chk("rst_fresh_event", key_data, 32'h8000_010F);
        chk("rst_fresh_pressed", 32'(key_pressed), 32'd1);
        finish_scan(0);
        scans(16'd0, 4);

        // Random key activity and pop timing, including pops landing on enqueue cycles.
        rk = 16'd0;
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel >= 75) begin
                if (sel < 84) begin
                    rk = 16'd0;
                end else if (sel < 96) begin
                    rk = 16'(1) << $urandom_range(0, 15);
                end else begin
                    int a, b;
                    a = int'($urandom_range(0, 15));
                    b = (a + 1 + int'($urandom_range(0, 14))) % 16;
                    rk = (16'(1) << a) | (16'(1) << b);
                end
            end
            sel = int'($urandom_range(0, 5));
            run_scan(rk, (sel < 2) ? sel + 1 : 0);
        end
        run_scan(16'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
